// File: rtl/ep2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ep2_pkg                                                                     |
// | Shared types and constants for the if/else dispatch datapath.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package ep2_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } dispatch_state_t;

  localparam int EP2_STAT_W = 32;

  // Wrapping packet counter step; the adder width matches the counter, so the
  // carry out of the top bit is simply lost.
  function automatic logic [EP2_STAT_W-1:0] stat_step(
    input logic [EP2_STAT_W-1:0] cur,
    input logic                  inc
  );
    return cur + EP2_STAT_W'(inc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axis_fifo                                                                   |
// | Data-only AXI-Stream FIFO, one cycle write-to-read latency.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module axis_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  push;
  logic                  pop;

  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Ready depends only on the stored count, so a pop in the same cycle never
  // lets a write into a full queue.
  assign s_axis_tready = (count_q != CNT_W'(DEPTH));
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifelse_dispatch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ifelse_dispatch                                                             |
// | Steers each value packet to the if/else stream chosen by a queued token.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ifelse_dispatch
  import ep2_pkg::*;
#(
  parameter int VAL_WIDTH      = 16,
  parameter int VAL_KEEP_WIDTH = VAL_WIDTH / 8,
  parameter int COND_WIDTH     = 1,
  parameter int IF_STREAM      = 1,
  parameter int FIFO_SIZE      = 16
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [COND_WIDTH-1:0]     s_cond_axis_tdata,
  input  logic                      s_cond_axis_tvalid,
  output logic                      s_cond_axis_tready,

  input  logic [VAL_WIDTH-1:0]      s_val_axis_tdata,
  input  logic [VAL_KEEP_WIDTH-1:0] s_val_axis_tkeep,
  input  logic                      s_val_axis_tvalid,
  input  logic                      s_val_axis_tlast,
  output logic                      s_val_axis_tready,

  output logic [VAL_WIDTH-1:0]      m_if_axis_tdata,
  output logic [VAL_KEEP_WIDTH-1:0] m_if_axis_tkeep,
  output logic                      m_if_axis_tvalid,
  output logic                      m_if_axis_tlast,
  input  logic                      m_if_axis_tready,

  output logic [VAL_WIDTH-1:0]      m_else_axis_tdata,
  output logic [VAL_KEEP_WIDTH-1:0] m_else_axis_tkeep,
  output logic                      m_else_axis_tvalid,
  output logic                      m_else_axis_tlast,
  input  logic                      m_else_axis_tready,

  output logic [EP2_STAT_W-1:0]     stat_if_pkts,
  output logic [EP2_STAT_W-1:0]     stat_else_pkts
);

  localparam logic FORCE_BEAT = (IF_STREAM == 0);

  dispatch_state_t           state_q, state_d;
  logic                      sel_q,   sel_d;

  logic [COND_WIDTH-1:0]     cond_head;
  logic                      cond_valid;
  logic                      cond_pop;

  logic [VAL_KEEP_WIDTH-1:0] val_keep;
  logic                      val_last;
  logic                      val_ready;
  logic                      val_accept;

  logic                      if_free,  else_free;
  logic                      if_load,  else_load;

  logic [VAL_WIDTH-1:0]      if_data_q,  else_data_q;
  logic [VAL_KEEP_WIDTH-1:0] if_keep_q,  else_keep_q;
  logic                      if_last_q,  else_last_q;
  logic                      if_valid_q, else_valid_q;

  logic [EP2_STAT_W-1:0]     if_pkts_q,  else_pkts_q;

  axis_fifo #(
    .DEPTH      (FIFO_SIZE),
    .DATA_WIDTH (COND_WIDTH)
  ) u_cond_fifo (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_cond_axis_tdata),
    .s_axis_tvalid (s_cond_axis_tvalid),
    .s_axis_tready (s_cond_axis_tready),
    .m_axis_tdata  (cond_head),
    .m_axis_tvalid (cond_valid),
    .m_axis_tready (cond_pop)
  );

  // In single-beat mode every beat is a full packet, whatever the sideband says.
  assign val_keep = s_val_axis_tkeep | {VAL_KEEP_WIDTH{FORCE_BEAT}};
  assign val_last = s_val_axis_tlast | FORCE_BEAT;

  assign if_free    = !if_valid_q   || m_if_axis_tready;
  assign else_free  = !else_valid_q || m_else_axis_tready;
  assign val_accept = s_val_axis_tvalid && val_ready;
  assign if_load    = val_accept &&  sel_q;
  assign else_load  = val_accept && !sel_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cond_pop  = 1'b0;
    val_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cond_valid) begin
          cond_pop = 1'b1;
          sel_d    = |cond_head;
          state_d  = ROUTE;
        end
      end
      ROUTE: begin
        val_ready = sel_q ? if_free : else_free;
        // Chaining the next token on the tlast beat keeps packets bubble-free.
        if (s_val_axis_tvalid && val_ready && val_last) begin
          if (cond_valid) begin
            cond_pop = 1'b1;
            sel_d    = |cond_head;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
      if_keep_q  <= '0;
      if_last_q  <= 1'b0;
    end else if (if_load) begin
      if_valid_q <= 1'b1;
      if_data_q  <= s_val_axis_tdata;
      if_keep_q  <= val_keep;
      if_last_q  <= val_last;
    end else if (m_if_axis_tready) begin
      if_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      else_valid_q <= 1'b0;
      else_data_q  <= '0;
      else_keep_q  <= '0;
      else_last_q  <= 1'b0;
    end else if (else_load) begin
      else_valid_q <= 1'b1;
      else_data_q  <= s_val_axis_tdata;
      else_keep_q  <= val_keep;
      else_last_q  <= val_last;
    end else if (m_else_axis_tready) begin
      else_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pkts_q   <= '0;
      else_pkts_q <= '0;
    end else begin
      if_pkts_q   <= stat_step(if_pkts_q,   if_load   && val_last);
      else_pkts_q <= stat_step(else_pkts_q, else_load && val_last);
    end
  end

  assign s_val_axis_tready  = val_ready;

  assign m_if_axis_tdata    = if_data_q;
  assign m_if_axis_tkeep    = if_keep_q;
  assign m_if_axis_tvalid   = if_valid_q;
  assign m_if_axis_tlast    = if_last_q;

  assign m_else_axis_tdata  = else_data_q;
  assign m_else_axis_tkeep  = else_keep_q;
  assign m_else_axis_tvalid = else_valid_q;
  assign m_else_axis_tlast  = else_last_q;

  assign stat_if_pkts       = if_pkts_q;
  assign stat_else_pkts     = else_pkts_q;

endmodule
`default_nettype wire
